// File: rtl/serial_host_bridge.sv
// ============================================================================
// Module   : serial_host_bridge
// Brief    : Host byte-stream framer/deframer driving the core cmd/in/out ports.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_host_bridge #(
  parameter int CMD_W  = 16,
  parameter int CONF_W = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rxByte,
  input  logic              rxByte_isReady,
  output logic              rxByte_canReceive,
  output logic [7:0]        txByte,
  output logic              txByte_isReady,
  input  logic              txByte_canReceive,
  output logic [CMD_W-1:0]  cmd,
  output logic              cmd_hasAny,
  input  logic              cmd_consume,
  output logic [63:0]       in,
  output logic              in_isReady,
  input  logic              in_canReceive,
  input  logic [63:0]       out,
  input  logic              out_isReady,
  output logic              out_canReceive,
  output logic [CONF_W-1:0] conf
);

  localparam int         c_CMD_B     = (CMD_W + 7) / 8;
  localparam int         c_CONF_B    = (CONF_W + 7) / 8;
  localparam logic [2:0] c_CMD_LAST  = 3'(c_CMD_B - 1);
  localparam logic [2:0] c_CONF_LAST = 3'(c_CONF_B - 1);
  localparam logic [2:0] c_DATA_LAST = 3'd7;

  typedef enum logic [2:0] {
    S_HDR        = 3'd0,
    S_PAYLOAD    = 3'd1,
    S_ISSUE_CMD  = 3'd2,
    S_ISSUE_DATA = 3'd3,
    S_RD_WAIT    = 3'd4,
    S_RD_SEND    = 3'd5
  } state_t;

  state_t      r_state, w_state;
  logic [1:0]  r_kind, w_kind;
  logic [2:0]  r_cnt, w_cnt;
  logic [63:0] r_buf, w_buf;
  logic [6:0]  r_words, w_words;
  logic [63:0] r_word, w_word;

  logic [CMD_W-1:0]  w_cmd;
  logic              w_cmd_has;
  logic [63:0]       w_in;
  logic              w_in_rdy;
  logic [CONF_W-1:0] w_conf;
  logic [7:0]        w_tx;
  logic              w_tx_rdy;
  logic [63:0]       w_frame;
  logic [2:0]        w_last;
  logic              w_rx_xfer;

  assign rxByte_canReceive = (r_state == S_HDR) || (r_state == S_PAYLOAD);
  assign out_canReceive    = (r_state == S_RD_WAIT);
  assign w_rx_xfer         = rxByte_isReady && rxByte_canReceive;

  always_comb begin
    w_state   = r_state;
    w_kind    = r_kind;
    w_cnt     = r_cnt;
    w_buf     = r_buf;
    w_words   = r_words;
    w_word    = r_word;
    w_cmd     = cmd;
    w_cmd_has = cmd_hasAny;
    w_in      = in;
    w_in_rdy  = in_isReady;
    w_conf    = conf;
    w_tx      = txByte;
    w_tx_rdy  = txByte_isReady;

    // Payload so far with the byte on the wire merged in at its little-endian slot
    w_frame = r_buf;
    w_frame[{r_cnt, 3'b000} +: 8] = rxByte;

    case (r_kind)
      2'b00:   w_last = c_CMD_LAST;
      2'b01:   w_last = c_DATA_LAST;
      default: w_last = c_CONF_LAST;
    endcase

    case (r_state)
      S_HDR: begin
        if (w_rx_xfer) begin
          if (rxByte[7:6] == 2'b11) begin
            w_words = (rxByte[5:0] == 6'd0) ? 7'd64 : {1'b0, rxByte[5:0]};
            w_state = S_RD_WAIT;
          end else begin
            w_kind  = rxByte[7:6];
            w_cnt   = 3'd0;
            w_buf   = '0;
            w_state = S_PAYLOAD;
          end
        end
      end
      S_PAYLOAD: begin
        if (w_rx_xfer) begin
          w_buf = w_frame;
          w_cnt = r_cnt + 3'd1;
          if (r_cnt == w_last) begin
            w_cnt = 3'd0;
            case (r_kind)
              2'b00: begin
                w_cmd     = w_frame[CMD_W-1:0];
                w_cmd_has = 1'b1;
                w_state   = S_ISSUE_CMD;
              end
              2'b01: begin
                w_in     = w_frame;
                w_in_rdy = 1'b1;
                w_state  = S_ISSUE_DATA;
              end
              default: begin
                w_conf  = w_frame[CONF_W-1:0];
                w_state = S_HDR;
              end
            endcase
          end
        end
      end
      S_ISSUE_CMD: begin
        if (cmd_consume) begin
          w_cmd     = '0;
          w_cmd_has = 1'b0;
          w_state   = S_HDR;
        end
      end
      S_ISSUE_DATA: begin
        if (in_canReceive) begin
          w_in     = '0;
          w_in_rdy = 1'b0;
          w_state  = S_HDR;
        end
      end
      S_RD_WAIT: begin
        if (out_isReady) begin
          w_word   = out;
          w_tx     = out[7:0];
          w_tx_rdy = 1'b1;
          w_cnt    = 3'd0;
          w_state  = S_RD_SEND;
        end
      end
      S_RD_SEND: begin
        if (txByte_canReceive) begin
          if (r_cnt == 3'd7) begin
            w_tx     = 8'd0;
            w_tx_rdy = 1'b0;
            w_cnt    = 3'd0;
            w_words  = r_words - 7'd1;
            w_state  = (r_words == 7'd1) ? S_HDR : S_RD_WAIT;
          end else begin
            w_cnt = r_cnt + 3'd1;
            w_tx  = r_word[{w_cnt, 3'b000} +: 8];
          end
        end
      end
      default: w_state = S_HDR;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= S_HDR;
      r_kind         <= 2'b00;
      r_cnt          <= 3'd0;
      r_buf          <= '0;
      r_words        <= 7'd0;
      r_word         <= '0;
      cmd            <= '0;
      cmd_hasAny     <= 1'b0;
      in             <= '0;
      in_isReady     <= 1'b0;
      conf           <= '0;
      txByte         <= 8'd0;
      txByte_isReady <= 1'b0;
    end else begin
      r_state        <= w_state;
      r_kind         <= w_kind;
      r_cnt          <= w_cnt;
      r_buf          <= w_buf;
      r_words        <= w_words;
      r_word         <= w_word;
      cmd            <= w_cmd;
      cmd_hasAny     <= w_cmd_has;
      in             <= w_in;
      in_isReady     <= w_in_rdy;
      conf           <= w_conf;
      txByte         <= w_tx;
      txByte_isReady <= w_tx_rdy;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_serial_host_bridge.sv
// ============================================================================
// Module   : tb_serial_host_bridge
// Brief    : Directed, table-driven self-checking bench for serial_host_bridge.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_host_bridge;

  localparam int CMD_W  = 16;
  localparam int CONF_W = 20;

  logic              clk = 1'b0;
  logic              rst;
  logic [7:0]        rxByte;
  logic              rxByte_isReady;
  logic              rxByte_canReceive;
  logic [7:0]        txByte;
  logic              txByte_isReady;
  logic              txByte_canReceive;
  logic [CMD_W-1:0]  cmd;
  logic              cmd_hasAny;
  logic              cmd_consume;
  logic [63:0]       in;
  logic              in_isReady;
  logic              in_canReceive;
  logic [63:0]       out;
  logic              out_isReady;
  logic              out_canReceive;
  logic [CONF_W-1:0] conf;

  always #5 clk = ~clk;

  serial_host_bridge #(.CMD_W(CMD_W), .CONF_W(CONF_W)) dut (
    .clk(clk), .rst(rst),
    .rxByte(rxByte), .rxByte_isReady(rxByte_isReady), .rxByte_canReceive(rxByte_canReceive),
    .txByte(txByte), .txByte_isReady(txByte_isReady), .txByte_canReceive(txByte_canReceive),
    .cmd(cmd), .cmd_hasAny(cmd_hasAny), .cmd_consume(cmd_consume),
    .in(in), .in_isReady(in_isReady), .in_canReceive(in_canReceive),
    .out(out), .out_isReady(out_isReady), .out_canReceive(out_canReceive),
    .conf(conf)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        rx_v;
    logic [7:0]  rx_b;
    logic        consume;
    logic        exp_rx_can;
    logic        exp_has;
    logic [15:0] exp_cmd;
    logic [19:0] exp_conf;
  } vec_t;

  vec_t        vecs [13];
  logic [63:0] rd_words [64];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got timeout expected handshake", name);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    rxByte         = b;
    rxByte_isReady = 1'b1;
    while (!rxByte_canReceive && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) fail_timeout("rx_accept");
    tick();
    rxByte_isReady = 1'b0;
  endtask

  task automatic do_read(input int nw, input bit stall, output int words_taken, output int bytes_seen);
    int widx = 0;
    int bidx = 0;
    int cyc  = 0;
    logic [7:0] expb;
    while (bidx < nw * 8 && cyc < nw * 40 + 50) begin
      out_isReady       = (widx < nw);
      out               = (widx < nw) ? rd_words[widx] : 64'd0;
      txByte_canReceive = stall ? cyc[0] : 1'b1;
      #1;
      if (out_isReady && out_canReceive) widx++;
      if (txByte_isReady && txByte_canReceive) begin
        expb = rd_words[bidx / 8][(bidx % 8) * 8 +: 8];
        check("rd_byte", {56'd0, txByte}, {56'd0, expb});
        bidx++;
      end
      tick();
      cyc++;
    end
    out_isReady       = 1'b0;
    txByte_canReceive = 1'b0;
    if (bidx < nw * 8) fail_timeout("rd_bytes");
    words_taken = widx;
    bytes_seen  = bidx;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int xfers;
    int nwords;
    int nbytes;

    // CMD frame with consume delayed 3 cycles, then a CONF frame
    vecs[0]  = '{1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 16'h0000, 20'h00000};
    vecs[1]  = '{1'b1, 8'h34, 1'b0, 1'b1, 1'b0, 16'h0000, 20'h00000};
    vecs[2]  = '{1'b1, 8'h12, 1'b0, 1'b1, 1'b0, 16'h0000, 20'h00000};
    vecs[3]  = '{1'b1, 8'h55, 1'b0, 1'b0, 1'b1, 16'h1234, 20'h00000};
    vecs[4]  = '{1'b1, 8'h55, 1'b0, 1'b0, 1'b1, 16'h1234, 20'h00000};
    vecs[5]  = '{1'b1, 8'h55, 1'b0, 1'b0, 1'b1, 16'h1234, 20'h00000};
    vecs[6]  = '{1'b1, 8'h55, 1'b1, 1'b0, 1'b1, 16'h1234, 20'h00000};
    vecs[7]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 16'h0000, 20'h00000};
    vecs[8]  = '{1'b1, 8'h80, 1'b0, 1'b1, 1'b0, 16'h0000, 20'h00000};
    vecs[9]  = '{1'b1, 8'hAB, 1'b0, 1'b1, 1'b0, 16'h0000, 20'h00000};
    vecs[10] = '{1'b1, 8'hCD, 1'b0, 1'b1, 1'b0, 16'h0000, 20'h00000};
    vecs[11] = '{1'b1, 8'h0E, 1'b0, 1'b1, 1'b0, 16'h0000, 20'h00000};
    vecs[12] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 16'h0000, 20'hECDAB};

    rst               = 1'b1;
    rxByte            = 8'd0;
    rxByte_isReady    = 1'b0;
    txByte_canReceive = 1'b0;
    cmd_consume       = 1'b0;
    in_canReceive     = 1'b0;
    out               = 64'd0;
    out_isReady       = 1'b0;
    tick();
    tick();
    check("rst_cmd",        {48'd0, cmd}, 64'd0);
    check("rst_cmd_hasAny", {63'd0, cmd_hasAny}, 64'd0);
    check("rst_in",         in, 64'd0);
    check("rst_in_isReady", {63'd0, in_isReady}, 64'd0);
    check("rst_conf",       {44'd0, conf}, 64'd0);
    check("rst_txByte",     {56'd0, txByte}, 64'd0);
    check("rst_tx_isReady", {63'd0, txByte_isReady}, 64'd0);
    check("rst_out_canRx",  {63'd0, out_canReceive}, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 13; i++) begin
      rxByte         = vecs[i].rx_b;
      rxByte_isReady = vecs[i].rx_v;
      cmd_consume    = vecs[i].consume;
      #1;
      check("vec_rx_can",  {63'd0, rxByte_canReceive}, {63'd0, vecs[i].exp_rx_can});
      check("vec_has",     {63'd0, cmd_hasAny},        {63'd0, vecs[i].exp_has});
      check("vec_cmd",     {48'd0, cmd},               {48'd0, vecs[i].exp_cmd});
      check("vec_conf",    {44'd0, conf},              {44'd0, vecs[i].exp_conf});
      check("vec_in_rdy",  {63'd0, in_isReady},        64'd0);
      @(posedge clk);
      #1;
    end
    rxByte_isReady = 1'b0;
    cmd_consume    = 1'b0;

    // DATA frame with in_canReceive toggling
    send_byte(8'h40);
    for (int k = 0; k < 8; k++) send_byte(8'(8 - k));
    check("data_in_rdy", {63'd0, in_isReady}, 64'd1);
    check("data_rx_can", {63'd0, rxByte_canReceive}, 64'd0);
    xfers = 0;
    for (int i = 0; i < 6; i++) begin
      in_canReceive = (i % 2 == 1);
      #1;
      if (in_isReady) check("data_in", in, 64'h0102030405060708);
      if (in_isReady && in_canReceive) xfers++;
      tick();
    end
    in_canReceive = 1'b0;
    check("data_xfers",   xfers, 64'd1);
    check("data_in_zero", in, 64'd0);
    check("data_in_rdy0", {63'd0, in_isReady}, 64'd0);
    check("data_conf",    {44'd0, conf}, 64'hECDAB);

    // READ two words with host stalling every other cycle
    rd_words[0] = 64'h1122334455667788;
    rd_words[1] = 64'hAABBCCDDEEFF0011;
    send_byte(8'hC2);
    do_read(2, 1'b1, nwords, nbytes);
    check("rd2_words", nwords, 64'd2);
    tick();
    check("rd2_hdr",      {63'd0, rxByte_canReceive}, 64'd1);
    check("rd2_out_can0", {63'd0, out_canReceive}, 64'd0);
    check("rd2_tx_rdy0",  {63'd0, txByte_isReady}, 64'd0);

    // READ with argument 0 means 64 words
    for (int k = 0; k < 64; k++) rd_words[k] = {8{8'(k)}} ^ 64'h0F1E2D3C4B5A6978;
    send_byte(8'hC0);
    do_read(64, 1'b0, nwords, nbytes);
    check("rd64_words", nwords, 64'd64);
    check("rd64_bytes", nbytes, 64'd512);
    tick();
    check("rd64_out_can0", {63'd0, out_canReceive}, 64'd0);
    check("rd64_hdr",      {63'd0, rxByte_canReceive}, 64'd1);

    // Reset during byte 5 of a DATA frame
    send_byte(8'h40);
    for (int k = 0; k < 4; k++) send_byte(8'hA0 + 8'(k));
    rxByte         = 8'h55;
    rxByte_isReady = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    check("rstd_in",     in, 64'd0);
    check("rstd_in_rdy", {63'd0, in_isReady}, 64'd0);
    check("rstd_conf",   {44'd0, conf}, 64'd0);
    check("rstd_has",    {63'd0, cmd_hasAny}, 64'd0);
    @(negedge clk);
    rst            = 1'b0;
    rxByte_isReady = 1'b0;

    // Reset during RD_SEND index 3
    send_byte(8'hC1);
    out         = 64'hCAFEBABEDEADBEEF;
    out_isReady = 1'b1;
    xfers = 0;
    while (!txByte_isReady && xfers < 10) begin
      tick();
      xfers++;
    end
    if (xfers >= 10) fail_timeout("rstr_tx_ready");
    out_isReady = 1'b0;
    check("rstr_byte0", {56'd0, txByte}, 64'hEF);
    txByte_canReceive = 1'b1;
    tick();
    tick();
    tick();
    check("rstr_byte3",  {56'd0, txByte}, 64'hDE);
    check("rstr_tx_rdy", {63'd0, txByte_isReady}, 64'd1);
    #2;
    rst = 1'b1;
    #1;
    check("rstr_tx0",     {56'd0, txByte}, 64'd0);
    check("rstr_tx_rdy0", {63'd0, txByte_isReady}, 64'd0);
    check("rstr_out_can", {63'd0, out_canReceive}, 64'd0);
    @(negedge clk);
    rst               = 1'b0;
    txByte_canReceive = 1'b0;

    // Clean CMD frame after the resets, consume already high
    cmd_consume = 1'b1;
    send_byte(8'h00);
    send_byte(8'hCD);
    send_byte(8'hAB);
    check("post_has",    {63'd0, cmd_hasAny}, 64'd1);
    check("post_cmd",    {48'd0, cmd}, 64'hABCD);
    check("post_in",     in, 64'd0);
    check("post_tx",     {56'd0, txByte}, 64'd0);
    check("post_tx_rdy", {63'd0, txByte_isReady}, 64'd0);
    tick();
    check("post_has0",   {63'd0, cmd_hasAny}, 64'd0);
    check("post_cmd0",   {48'd0, cmd}, 64'd0);
    check("post_rx_can", {63'd0, rxByte_canReceive}, 64'd1);
    cmd_consume = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/serial_host_bridge.md
# serial_host_bridge

Byte-stream front end that drives `main_core_serialCmd` from a host link: parses framed bytes into core commands, 64-bit input words and configuration, and serialises 64-bit core output words back into bytes. It sits between the host-side byte transport (UART/FIFO) and the core, acting as the initiator for the core's `cmd`, `in` and `out` handshakes.

## Interface
- `CMD_W`, 16: width of `cmd`, equal to `MainCoreCMD_which_SIZE+MainCoreSerialCMD_SIZE`; `CMD_B = ceil(CMD_W/8)` payload bytes.
- `CONF_W`, 20: width of `conf`, equal to `MemCONF_matrixNumBlocks_size+4*3`; `CONF_B = ceil(CONF_W/8)` payload bytes.
- `clk`  in  1  clock, all state on posedge.
- `rst`  in  1  asynchronous, active-high reset.
- `rxByte`  in  8  host byte.
- `rxByte_isReady`  in  1  host has a byte.
- `rxByte_canReceive`  out  1  bridge accepts a byte this cycle.
- `txByte`  out  8  byte to host.
- `txByte_isReady`  out  1  `txByte` valid.
- `txByte_canReceive`  in  1  host accepts a byte.
- `cmd`  out  CMD_W  command to core.
- `cmd_hasAny`  out  1  command valid.
- `cmd_consume`  in  1  core takes command.
- `in`  out  64  data word to core.
- `in_isReady`  out  1  data word valid.
- `in_canReceive`  in  1  core accepts data word.
- `out`  in  64  core output word.
- `out_isReady`  in  1  core output valid.
- `out_canReceive`  out  1  bridge accepts output word.
- `conf`  out  CONF_W  configuration held for the core.

## Operation
- Transfer on any interface happens at a posedge where valid (`*_isReady`/`cmd_hasAny`) and ready (`*_canReceive`/`cmd_consume`) are both 1.
- Header byte `h`: type `h[7:6]`, argument `h[5:0]`.
  - 00 CMD: next `CMD_B` bytes, little-endian (first byte -> bits 7:0), upper unused bits dropped.
  - 01 DATA: next 8 bytes, little-endian, form `in`.
  - 10 CONF: next `CONF_B` bytes, little-endian, loaded into `conf`.
  - 11 READ: read `N` core words, `N = h[5:0]`, 0 means 64.
- States: HDR, PAYLOAD (byte counter), ISSUE_CMD, ISSUE_DATA, RD_WAIT, RD_SEND (byte index 0..7), words-remaining counter.
- HDR/PAYLOAD: `rxByte_canReceive`=1; all other states 0, so the bridge never buffers more than one frame.
- Last payload byte accepted: CMD -> ISSUE_CMD; DATA -> ISSUE_DATA; CONF -> `conf` updated at that same edge, back to HDR.
- ISSUE_CMD: `cmd_hasAny`=1, `cmd` stable until `cmd_consume`, then `cmd` cleared to 0, HDR.
- ISSUE_DATA: `in_isReady`=1, `in` stable until `in_canReceive`, then `in` cleared to 0, HDR.
- READ header accepted -> RD_WAIT with counter=N. RD_WAIT: `out_canReceive`=1; on transfer, capture `out` -> RD_SEND index 0.
- RD_SEND: `txByte_isReady`=1, `txByte` = byte[index] (LSB byte first); advance on `txByte_canReceive`. After index 7: counter-1; nonzero -> RD_WAIT, zero -> HDR.
- Host ordering is the host's responsibility: a READ issued before the core can produce data stalls indefinitely; no timeout.

## Timing
- Reset (async, immediate): state HDR, counters 0, `cmd`=0, `in`=0, `conf`=0, `txByte`=0, all valid/ready outputs 0 except `rxByte_canReceive`=1 in the first cycle after reset release.
- Reset mid-frame or mid-read discards the partial frame/word; `conf` returns to 0.
- All outputs are registered except `rxByte_canReceive` and `out_canReceive`, which decode state only and never depend on inputs.
- CMD frame: `cmd_hasAny` rises the cycle after the last payload byte; with `cmd_consume` already high, 1 issue cycle, HDR the following cycle. Minimum frame cost: 1+`CMD_B`+1 cycles.
- DATA: 1+8+1 cycles minimum; CONF: 1+`CONF_B` cycles, `conf` visible the cycle after the last byte.
- READ: RD_WAIT to first `txByte_isReady` is 1 cycle; a word takes 8 cycles with `txByte_canReceive` held high; ≥1 RD_WAIT cycle between words.
- `rxByte_isReady` while not in HDR/PAYLOAD is ignored, no byte lost (host holds it).

## Test plan
- CMD frame 0x00,0x34,0x12 with `cmd_consume` delayed 3 cycles -> `cmd`=0x1234, `cmd_hasAny` high exactly 4 cycles, `rxByte_canReceive` 0 throughout.
- DATA frame 0x40 then bytes 0x08..0x01 -> `in`=0x0102030405060708; with `in_canReceive` toggling 0/1, single transfer, `in` returns to 0.
- CONF frame 0x80,0xAB,0xCD,0x0E -> `conf`=20'hECDAB the cycle after the last byte, no core handshake.
- READ 0xC2, core supplies 0x1122334455667788 then 0xAABBCCDDEEFF0011, `txByte_canReceive` stalling every other cycle -> bytes 88,77,...,11,11,00,FF,...,AA in order, then HDR.
- READ header 0xC0 -> exactly 64 words consumed, 512 bytes emitted.
- `rst` asserted during byte 5 of DATA and during RD_SEND index 3 -> all outputs reset immediately; subsequent CMD frame processed correctly, no stale `in`/`txByte`.
